pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Sequences the program counter for the processor core: issues fetches, waits for execute completion, selects next PC (sequential, PC-relative branch, register branch).
- Owns the PC register and the branch-target adder path (PC + sign-extended word offset << 2).
- Sits between instruction memory and decode/execute; replaces the free-running PC update with a handshaked, multi-cycle sequence.

Parameters:
- XLEN, 64, width of PC and offsets
- RESET_VECTOR, 64'h0, PC loaded on reset
- FETCH_TIMEOUT, 16, max cycles waiting for imem_ack before error (>=2)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request, held until imem_ack
- imem_addr  out  XLEN  fetch address (= pc while imem_req)
- imem_ack  in  1  instruction word valid this cycle
- instr_valid  out  1  one-cycle pulse: fetched instruction handed to datapath
- exec_done  in  1  datapath finished current instruction; branch inputs valid this cycle
- br_uncond  in  1  unconditional PC-relative branch (B)
- br_cond  in  1  conditional PC-relative branch (CBZ/CBNZ/B.cond)
- br_cond_taken  in  1  condition result for br_cond
- br_reg  in  1  register-indirect branch (BR)
- br_offset  in  XLEN  sign-extended word offset from sign-extend unit
- br_reg_target  in  XLEN  target address from register file
- halt  in  1  stop after current instruction
- pc  out  XLEN  current PC
- halted  out  1  sequencer in HALT
- err  out  2  00 none, 01 fetch timeout, 10 misaligned target

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_VECTOR, imem_req=0, instr_valid=0, halted=0, err=00, timeout counter=0. Reset asserted mid-fetch/exec aborts immediately; imem_req drops asynchronously.
- IDLE: one cycle after reset release -> FETCH.
- FETCH: imem_req=1, imem_addr=pc; counter increments each cycle. imem_ack=1 -> instr_valid pulse next cycle, state EXEC, counter cleared. Counter reaching FETCH_TIMEOUT without ack -> err=01, HALT.
- Fetch latency: imem_req asserted in cycle 1 after reset release; an ack in cycle k gives instr_valid in cycle k+1.
- EXEC: wait for exec_done; imem_ack ignored here. On exec_done compute next_pc, register in UPDATE.
- next_pc priority: br_reg -> br_reg_target; else br_uncond -> pc + (br_offset << 2); else br_cond & br_cond_taken -> pc + (br_offset << 2); else pc + 4.
- Arithmetic: all sums modulo 2^XLEN (wrap, no overflow flag); shift discards top 2 offset bits; br_offset treated as two's complement.
- UPDATE: pc <= next_pc. If next_pc[1:0] != 0 (only possible via br_reg) -> err=10, pc unchanged, HALT. Else halt sampled -> HALT, otherwise FETCH.
- halt: sticky-latched whenever asserted in EXEC/FETCH; honoured only at UPDATE (current instruction always completes, PC always updated first). halt during IDLE latched likewise.
- HALT: halted=1, imem_req=0; exits only by reset. err holds value.
- Branch inputs ignored when exec_done=0.

Decomposition:
- Shared package: state encoding (IDLE, FETCH, EXEC, UPDATE, HALT), err codes, PC_INCR=4, RESET_VECTOR default.
- One sub-module natural: branch_target_adder (combinational pc + (offset<<2), XLEN-parameterised); the sequencer instantiates it and the pc+4 adder.

Test Plan:
- Reset release, ack 2 cycles after req -> imem_addr=0x0, instr_valid one cycle after ack; exec_done no branch -> next fetch imem_addr=0x4.
- pc=0x100, br_uncond=1, br_offset=-15 (0xFFFF_FFFF_FFFF_FFF1) -> pc=0xC4; br_offset=5 from 0x100 -> pc=0x114.
- pc=0x0, br_uncond, br_offset=-1 -> pc=0xFFFF_FFFF_FFFF_FFFC (wrap); br_cond=1, br_cond_taken=0 -> pc+4.
- br_reg=1 and br_uncond=1 together, br_reg_target=0x2000 -> pc=0x2000; br_reg_target=0x2002 -> err=10, halted=1, pc unchanged.
- No imem_ack for FETCH_TIMEOUT=16 cycles -> err=01, halted=1, imem_req=0; rst_n pulse mid-FETCH -> outputs to reset values same cycle, restart at RESET_VECTOR.
- halt asserted in FETCH, exec_done with pc=0x40 -> pc=0x44, halted=1, no further imem_req.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: state encoding,
// error codes and PC defaults.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_UPDATE,
    ST_HALT
  } seq_state_e;

  localparam logic [1:0] ERR_NONE          = 2'b00;
  localparam logic [1:0] ERR_FETCH_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_MISALIGNED    = 2'b10;

  localparam int unsigned PC_INCR              = 4;
  localparam logic [63:0] RESET_VECTOR_DEFAULT = 64'h0;

endpackage

// File: rtl/pc_sequencer_branch_target_adder.sv
// PC-relative branch target: pc + (word offset << 2), wrapping modulo 2^XLEN.
module pc_sequencer_branch_target_adder #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] offset_i,
  output logic [XLEN-1:0] target_o
);

  assign target_o = pc_i + (offset_i << 2);

endmodule

// File: rtl/pc_sequencer.sv
// Handshaked program-counter sequencer: fetch, wait for execute, select the
// next PC (sequential / PC-relative / register branch), with timeout and
// alignment error detection.
//
// state  | meaning
// IDLE   | one cycle after reset release
// FETCH  | imem_req high, waiting for imem_ack, timeout counting
// EXEC   | instruction handed over, waiting for exec_done
// UPDATE | commit next_pc or flag misaligned target
// HALT   | stopped; only reset exits
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              XLEN          = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR  = XLEN'(RESET_VECTOR_DEFAULT),
  parameter int              FETCH_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  output logic            instr_valid,
  input  logic            exec_done,
  input  logic            br_uncond,
  input  logic            br_cond,
  input  logic            br_cond_taken,
  input  logic            br_reg,
  input  logic [XLEN-1:0] br_offset,
  input  logic [XLEN-1:0] br_reg_target,
  input  logic            halt,
  output logic [XLEN-1:0] pc,
  output logic            halted,
  output logic [1:0]      err
);

  localparam int            CNT_W        = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  seq_state_e       state_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  next_pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             imem_req_q;
  logic             instr_valid_q;
  logic             halted_q;
  logic             halt_q;
  logic [1:0]       err_q;

  logic [XLEN-1:0]  br_target;
  logic [XLEN-1:0]  pc_plus4;
  logic [XLEN-1:0]  next_pc_d;

  pc_sequencer_branch_target_adder #(
    .XLEN (XLEN)
  ) u_br_adder (
    .pc_i     (pc_q),
    .offset_i (br_offset),
    .target_o (br_target)
  );

  assign pc_plus4 = pc_q + XLEN'(PC_INCR);

  // Register-indirect wins over any PC-relative request.
  always_comb begin
    next_pc_d = pc_plus4;
    if (br_reg) begin
      next_pc_d = br_reg_target;
    end else if (br_uncond || (br_cond && br_cond_taken)) begin
      next_pc_d = br_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_VECTOR;
      next_pc_q     <= RESET_VECTOR;
      cnt_q         <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      halt_q        <= 1'b0;
      err_q         <= ERR_NONE;
    end else begin
      instr_valid_q <= 1'b0;
      if (halt && (state_q != ST_HALT)) begin
        halt_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          state_q    <= ST_FETCH;
          imem_req_q <= 1'b1;
          cnt_q      <= '0;
        end
        ST_FETCH: begin
          if (imem_ack) begin
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
            cnt_q         <= '0;
            state_q       <= ST_EXEC;
          end else if (cnt_q == TIMEOUT_LAST) begin
            imem_req_q <= 1'b0;
            err_q      <= ERR_FETCH_TIMEOUT;
            halted_q   <= 1'b1;
            state_q    <= ST_HALT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_EXEC: begin
          if (exec_done) begin
            next_pc_q <= next_pc_d;
            state_q   <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          // Only a register target can be misaligned; pc keeps the faulting instruction.
          if (next_pc_q[1:0] != 2'b00) begin
            err_q    <= ERR_MISALIGNED;
            halted_q <= 1'b1;
            state_q  <= ST_HALT;
          end else begin
            pc_q <= next_pc_q;
            if (halt_q || halt) begin
              halted_q <= 1'b1;
              state_q  <= ST_HALT;
            end else begin
              imem_req_q <= 1'b1;
              cnt_q      <= '0;
              state_q    <= ST_FETCH;
            end
          end
        end
        ST_HALT: begin
          imem_req_q <= 1'b0;
          halted_q   <= 1'b1;
        end
        default: begin
          imem_req_q <= 1'b0;
          halted_q   <= 1'b1;
          state_q    <= ST_HALT;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign err         = err_q;

endmodule
